// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed decimating FIR.
// The default coefficient set is a symmetric Q1.15 low-pass whose taps sum to unity gain.
package fir_pkg;

    localparam int unsigned DEF_TAPS      = 16;
    localparam int unsigned DEF_DECIM     = 4;
    localparam int unsigned DEF_COEF_FRAC = 15;
    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned COEF_W        = 16;
    localparam int unsigned ACC_W         = 32 + $clog2(DEF_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        ROUND
    } fir_state_t;

    localparam logic signed [COEF_W-1:0] COEFS [DEF_TAPS] = '{
        16'sd256,  16'sd512,  16'sd1024, 16'sd1536,
        16'sd2304, 16'sd3072, 16'sd3584, 16'sd4096,
        16'sd4096, 16'sd3584, 16'sd3072, 16'sd2304,
        16'sd1536, 16'sd1024, 16'sd512,  16'sd256
    };

    // Flattened form lets a build pass an alternative set through a plain packed parameter.
    function automatic logic [DEF_TAPS*COEF_W-1:0] pack_coefs();
        logic [DEF_TAPS*COEF_W-1:0] flat;
        flat = '0;
        for (int unsigned i = 0; i < DEF_TAPS; i++) begin
            flat[i*COEF_W +: COEF_W] = COEFS[i];
        end
        return flat;
    endfunction

    localparam logic [DEF_TAPS*COEF_W-1:0] COEFS_FLAT = pack_coefs();

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational tap-index to coefficient lookup; the table arrives as a flattened
// parameter (tap 0 in the low bits) so each build can swap the coefficient set.
module fir_coef_rom
    import fir_pkg::*;
#(
    parameter int unsigned                   TAPS       = DEF_TAPS,
    parameter logic [TAPS*COEF_W-1:0]        COEF_TABLE = COEFS_FLAT
) (
    input  logic [$clog2(TAPS)-1:0]  tap_idx,
    output logic signed [COEF_W-1:0] coef
);

    always_comb begin
        coef = COEF_TABLE[tap_idx*COEF_W +: COEF_W];
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Decimating FIR built around one shared multiply-accumulate: every sample enters the
// circular history, but only every DECIM-th sample launches the TAPS-cycle tap loop.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned            TAPS       = DEF_TAPS,
    parameter int unsigned            DECIM      = DEF_DECIM,
    parameter int unsigned            COEF_FRAC  = DEF_COEF_FRAC,
    parameter logic [TAPS*COEF_W-1:0] COEF_TABLE = COEFS_FLAT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] audio_in,
    input  logic        audio_sample_valid,
    output logic [15:0] dec_output,
    output logic        dec_output_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned IDX_W = $clog2(TAPS);
    localparam int unsigned DC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned MAC_W = 32 + IDX_W;

    localparam logic signed [MAC_W-1:0] RND_BIAS = MAC_W'(64'd1 << (COEF_FRAC - 1));
    localparam logic signed [MAC_W-1:0] SAT_MAX  = MAC_W'((64'd1 << (SAMPLE_W - 1)) - 64'd1);
    localparam logic signed [MAC_W-1:0] SAT_MIN  = ~SAT_MAX;

    fir_state_t state_q, state_d;

    logic signed [SAMPLE_W-1:0] hist [TAPS];
    logic [IDX_W-1:0]           wr_ptr;
    logic [IDX_W-1:0]           newest;
    logic [IDX_W-1:0]           tap_idx;
    logic [IDX_W-1:0]           rd_idx;
    logic [DC_W-1:0]            decim_cnt;
    logic signed [MAC_W-1:0]    acc;

    logic signed [SAMPLE_W-1:0] pend_data;
    logic                       pend_full;

    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_data;
    logic                       last_of_group;

    logic                       take_sample;
    logic                       acc_clr;
    logic                       mac_en;
    logic                       round_en;

    logic signed [SAMPLE_W-1:0]        tap_sample;
    logic signed [COEF_W-1:0]          tap_coef;
    logic signed [SAMPLE_W+COEF_W-1:0] product;
    logic signed [MAC_W-1:0]           acc_rounded;
    logic [SAMPLE_W-1:0]               round_out;

    fir_coef_rom #(
        .TAPS       (TAPS),
        .COEF_TABLE (COEF_TABLE)
    ) u_coef_rom (
        .tap_idx (tap_idx),
        .coef    (tap_coef)
    );

    // The pending slot always has priority over a fresh strobe arriving in the same cycle.
    always_comb begin
        in_valid      = pend_full | audio_sample_valid;
        in_data       = pend_full ? pend_data : $signed(audio_in);
        last_of_group = (decim_cnt == DC_W'(DECIM - 1));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid && last_of_group) state_d = LOAD;
            LOAD:    state_d = MAC;
            MAC:     if (tap_idx == IDX_W'(TAPS - 1)) state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        take_sample = (state_q == IDLE) && in_valid;
        acc_clr     = (state_q == LOAD);
        mac_en      = (state_q == MAC);
        round_en    = (state_q == ROUND);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            wr_ptr    <= '0;
            newest    <= '0;
            decim_cnt <= '0;
        end else if (take_sample) begin
            hist[wr_ptr] <= in_data;
            newest       <= wr_ptr;
            wr_ptr       <= wr_ptr + IDX_W'(1);
            decim_cnt    <= last_of_group ? '0 : decim_cnt + DC_W'(1);
        end
    end

    // One-deep skid for a sample that lands while the tap loop owns the datapath.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend_data <= '0;
            pend_full <= 1'b0;
            overrun   <= 1'b0;
        end else if (busy) begin
            if (audio_sample_valid) begin
                if (!pend_full) begin
                    pend_data <= $signed(audio_in);
                    pend_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end else if (pend_full) begin
            if (audio_sample_valid) begin
                pend_data <= $signed(audio_in);
            end else begin
                pend_full <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_idx     = newest - tap_idx;
        tap_sample = hist[rd_idx];
        product    = tap_sample * tap_coef;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc     <= '0;
            tap_idx <= '0;
        end else if (acc_clr) begin
            acc     <= '0;
            tap_idx <= '0;
        end else if (mac_en) begin
            acc     <= acc + MAC_W'(product);
            tap_idx <= tap_idx + IDX_W'(1);
        end
    end

    always_comb begin
        acc_rounded = (acc + RND_BIAS) >>> COEF_FRAC;
        if (acc_rounded > SAT_MAX) begin
            round_out = SAT_MAX[SAMPLE_W-1:0];
        end else if (acc_rounded < SAT_MIN) begin
            round_out = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            round_out = acc_rounded[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dec_output       <= '0;
            dec_output_ready <= 1'b0;
        end else begin
            dec_output_ready <= round_en;
            if (round_en) begin
                dec_output <= round_out;
            end
        end
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed controller for the audio anti-alias/decimation FIR. It replaces the fully parallel filter-plus-decimator with one shared multiply-accumulate unit. Every input sample is stored in a circular history buffer, but the tap loop runs only on samples that produce a decimated output. It sits between the audio sample source (mic/ADC path) and the downstream transcription/FFT front end.

Parameters:
TAPS, 16, number of FIR taps; power of two, 4..64.
DECIM, 4, decimation ratio; one output per DECIM accepted input samples.
COEF_FRAC, 15, fractional bits of the Q1.15 coefficients; output = rounded accumulator >>> COEF_FRAC.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  reset, asynchronous, active-high.
audio_in  input  16  signed input sample.
audio_sample_valid  input  1  one-cycle strobe qualifying audio_in.
dec_output  output  16  signed decimated, filtered sample; held between strobes.
dec_output_ready  output  1  one-cycle strobe, dec_output valid.
busy  output  1  high while the tap loop or output stage is active.
overrun  output  1  sticky; a sample was dropped; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): all outputs 0; history buffer zeroed; wr_ptr=0; decim_cnt=0; acc=0; pending slot empty; state=IDLE.
- States: IDLE, LOAD, MAC, ROUND.
- IDLE, valid sample present (pending slot or audio_sample_valid): write the sample to hist[wr_ptr]; newest=wr_ptr; wr_ptr advances modulo TAPS. The pending slot is consumed before a fresh input.
  - If decim_cnt==DECIM-1: decim_cnt->0, go to LOAD.
  - Else decim_cnt+1; stay in IDLE.
- LOAD (1 cycle): acc=0, tap index k=0.
- MAC (TAPS cycles): acc += hist[(newest-k) mod TAPS] * coef[k]; k+1.
  - Signed 16x16 products; acc width 32+log2(TAPS), no overflow possible.
  - After k=TAPS-1, go to ROUND.
- ROUND (1 cycle): r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, saturated to [-32768, 32767].
  - dec_output<=r and dec_output_ready<=1 for one cycle; return to IDLE.
- Latency: dec_output_ready is high TAPS+3 cycles after the triggering audio_sample_valid edge (write, LOAD, TAPS MACs, ROUND).
- busy=1 in LOAD, MAC and ROUND; 0 in IDLE.
- audio_sample_valid while busy:
  - Sample is captured into a one-deep pending slot.
  - If the slot is already full, the new sample is dropped, overrun<=1, and the slot keeps the older sample.
- audio_sample_valid in IDLE while pending is full cannot occur, because pending is drained on the first IDLE cycle. If both coincide anyway, pending is written first and the fresh sample takes the slot.
- History wraps modulo TAPS. Samples before reset are treated as zero.
- Reset mid-MAC aborts immediately. No dec_output_ready is emitted and the partial acc is discarded.
- Throughput requirement: the sample interval must be at least TAPS+3 cycles per decimated output. The pending slot absorbs one early sample.

Decomposition:
- Package fir_pkg holds:
  - the state enum (IDLE, LOAD, MAC, ROUND);
  - the coefficient array COEFS[TAPS] (signed Q1.15, symmetric low-pass, sum = 32768);
  - the constants SAMPLE_W=16, COEF_W=16, ACC_W.
- Sub-module fir_coef_rom: synchronous-read-free combinational lookup, tap index -> coefficient. It is kept separate so the coefficient set can be swapped per build.

Test Plan:
1. Reset, then 4 valids of audio_in=1000 spaced 40 cycles -> exactly one dec_output_ready, 19 cycles after the 4th valid. Value = round(1000 * sum of the 4 newest-aligned taps / 32768), checked against a model.
2. Constant 1000 for 64 samples -> from the 16th sample onward, every strobe gives dec_output=1000 (±1). One strobe per 4 inputs.
3. Impulse 32767 then zeros, 64 samples -> the strobe sequence matches coef[3], coef[7], coef[11], coef[15] scaled by 32767/32768 and rounded, then 0.
4. Constant 32767 with coefficients overdriven (test COEFS sum 40000) -> dec_output saturates at 32767; -32768 input saturates at -32768.
5. Two valids one cycle apart during MAC -> first goes to pending, second is dropped, overrun=1 and stays 1; the next output includes only the pending sample.
6. rst_in pulsed at MAC cycle 7 -> all outputs 0 immediately with no strobe. The next 4 valids produce an output computed from zeroed history.
